// File: rtl/mips32_multi.sv
// Multicycle MIPS32 subset core (add/sub/and/or/slt, lw, sw, beq, addi, j) with one shared
// req/ready memory port. Define MIPS32_PERF_EN to add cycle_cnt/instret_cnt counters.
module mips32_multi #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        trap
`ifdef MIPS32_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecute,
    StAluWb, StAddiEx, StAddiWb, StBranch, StJump, StTrap
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  state_e      r_state, w_state_next;
  logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_alu_out;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_imm_sext, w_rs_val, w_rt_val, w_alu_res;
  logic        w_funct_ok, w_illegal;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;

  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_funct    = r_ir[5:0];
  assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};

  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

  assign w_funct_ok = (w_funct == FnAdd) || (w_funct == FnSub) || (w_funct == FnAnd) ||
                      (w_funct == FnOr)  || (w_funct == FnSlt);

  always_comb begin
    w_illegal = 1'b0;
    unique case (w_op)
      OpRtype:                          w_illegal = !w_funct_ok;
      OpJ, OpBeq, OpAddi, OpLw, OpSw:   w_illegal = 1'b0;
      default:                          w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_alu_res = 32'd0;
    unique case (w_funct)
      FnAdd:   w_alu_res = r_a + r_b;
      FnSub:   w_alu_res = r_a - r_b;
      FnAnd:   w_alu_res = r_a & r_b;
      FnOr:    w_alu_res = r_a | r_b;
      FnSlt:   w_alu_res = {31'd0, $signed(r_a) < $signed(r_b)};
      default: w_alu_res = 32'd0;
    endcase
  end

  // Memory-side outputs depend only on state and holding registers, so they stay put during waits.
  assign mem_req   = reset && ((r_state == StFetch) || (r_state == StMemRead) ||
                               (r_state == StMemWrite));
  assign mem_write = reset && (r_state == StMemWrite);
  assign mem_addr  = (r_state == StFetch) ? {r_pc[31:2], 2'b00} : {r_alu_out[31:2], 2'b00};
  assign mem_wdata = r_b;
  assign pc        = r_pc;
  assign trap      = (r_state == StTrap);

  always_comb begin
    w_state_next = r_state;
    w_rf_we      = 1'b0;
    w_rf_waddr   = w_rt;
    w_rf_wdata   = r_alu_out;
    unique case (r_state)
      StFetch:    if (mem_ready) w_state_next = StDecode;
      StDecode: begin
        if (w_illegal) begin
          w_state_next = TRAP_ON_ILLEGAL ? StTrap : StFetch;
        end else begin
          unique case (w_op)
            OpLw, OpSw: w_state_next = StMemAdr;
            OpRtype:    w_state_next = StExecute;
            OpBeq:      w_state_next = StBranch;
            OpAddi:     w_state_next = StAddiEx;
            default:    w_state_next = StJump;
          endcase
        end
      end
      StMemAdr:   w_state_next = (w_op == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) w_state_next = StMemWb;
      StMemWb: begin
        w_rf_we      = 1'b1;
        w_rf_wdata   = r_mdr;
        w_state_next = StFetch;
      end
      StMemWrite: if (mem_ready) w_state_next = StFetch;
      StExecute:  w_state_next = StAluWb;
      StAluWb: begin
        w_rf_we      = 1'b1;
        w_rf_waddr   = w_rd;
        w_state_next = StFetch;
      end
      StAddiEx:   w_state_next = StAddiWb;
      StAddiWb: begin
        w_rf_we      = 1'b1;
        w_state_next = StFetch;
      end
      StBranch:   w_state_next = StFetch;
      StJump:     w_state_next = StFetch;
      StTrap:     w_state_next = StTrap;
      default:    w_state_next = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StFetch;
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_mdr     <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_alu_out <= 32'd0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StFetch: begin
          if (mem_ready) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + 32'd4;
          end
        end
        StDecode: begin
          r_a       <= w_rs_val;
          r_b       <= w_rt_val;
          r_alu_out <= r_pc + {w_imm_sext[29:0], 2'b00};
        end
        StMemAdr, StAddiEx: r_alu_out <= r_a + w_imm_sext;
        StMemRead: if (mem_ready) r_mdr <= mem_rdata;
        StExecute: r_alu_out <= w_alu_res;
        StBranch:  if (r_a == r_b) r_pc <= r_alu_out;
        StJump:    r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  // Register file has no reset; $0 is never written and reads back as zero.
  always_ff @(posedge clk) begin
    if (reset && w_rf_we && (w_rf_waddr != 5'd0)) begin
      r_rf[w_rf_waddr] <= w_rf_wdata;
    end
  end

`ifdef MIPS32_PERF_EN
  logic [31:0] r_cycle_cnt, r_instret_cnt;
  logic        w_retire;

  always_comb begin
    w_retire = 1'b0;
    unique case (r_state)
      StMemWb, StAluWb, StAddiWb, StBranch, StJump: w_retire = 1'b1;
      StMemWrite: w_retire = mem_ready;
      StDecode:   w_retire = w_illegal && !TRAP_ON_ILLEGAL;
      default:    w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      if (r_state != StTrap) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire) r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_mips32_multi.sv
// Scoreboarded bench for mips32_multi: two cores (trapping at 0, NOP-on-illegal at 0xF0000000),
// expected memory accesses queued by the stimulus and checked by a monitor at each accept.
module tb_mips32_multi;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } acc_t;

  logic        clk = 1'b0;
  logic        a_rst_n, b_rst_n;
  logic [31:0] a_pc, a_addr, a_wdata, a_rdata, b_pc, b_addr, b_wdata, b_rdata;
  logic        a_req, a_write, a_ready, a_trap, b_req, b_write, b_ready, b_trap;
`ifdef MIPS32_PERF_EN
  logic [31:0] a_cyc, a_inst, b_cyc, b_inst;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int unsigned a_delay = 0;
  int unsigned a_cnt   = 0;
  int          a_phase = 0;
  logic [31:0] a_ram [64];
  acc_t        qa[$];
  acc_t        qb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] rom_a(input int ph, input logic [5:0] idx);
    logic [31:0] w;
    w = 32'hFC00_0000;
    if (ph == 0) begin
      case (idx)
        6'd0:  w = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        6'd1:  w = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        6'd2:  w = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        6'd3:  w = enc_i(6'h2B, 5'd0, 5'd3, 16'h0100);
        6'd4:  w = enc_i(6'h23, 5'd0, 5'd4, 16'h0100);
        6'd5:  w = enc_i(6'h2B, 5'd0, 5'd4, 16'h0104);
        6'd6:  w = enc_r(5'd1, 5'd2, 5'd5, 6'h22);
        6'd7:  w = enc_r(5'd5, 5'd1, 5'd6, 6'h2A);
        6'd8:  w = enc_r(5'd1, 5'd2, 5'd7, 6'h24);
        6'd9:  w = enc_r(5'd1, 5'd2, 5'd8, 6'h25);
        6'd10: w = enc_i(6'h2B, 5'd0, 5'd5, 16'h0108);
        6'd11: w = enc_i(6'h2B, 5'd0, 5'd6, 16'h010C);
        6'd12: w = enc_i(6'h2B, 5'd0, 5'd7, 16'h0110);
        6'd13: w = enc_i(6'h2B, 5'd0, 5'd8, 16'h0114);
        6'd14: w = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
        6'd15: w = enc_i(6'h04, 5'd1, 5'd1, 16'd1);
        6'd17: w = enc_i(6'h23, 5'd0, 5'd9, 16'h0100);
        6'd18: w = enc_i(6'h04, 5'd9, 5'd3, 16'hFFFF);
        default: w = 32'hFC00_0000;
      endcase
    end else if (ph == 2) begin
      if (idx == 6'd0) w = enc_i(6'h23, 5'd0, 5'd4, 16'h0118);
    end else if (ph == 3) begin
      case (idx)
        6'd0: w = enc_i(6'h2B, 5'd0, 5'd4, 16'h011C);
        6'd1: w = enc_i(6'h23, 5'd0, 5'd11, 16'h0103);
        6'd2: w = enc_i(6'h2B, 5'd0, 5'd11, 16'h0121);
        6'd3: w = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
        default: w = 32'hFC00_0000;
      endcase
    end
    return w;
  endfunction

  function automatic logic [31:0] rom_b(input logic [7:0] idx);
    logic [31:0] w;
    case (idx)
      8'h00:   w = {6'h02, 26'h000_0040};
      8'h41:   w = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
      8'h42:   w = enc_i(6'h2B, 5'd0, 5'd0, 16'h0200);
      8'h43:   w = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
      8'h44:   w = enc_i(6'h2B, 5'd0, 5'd1, 16'h0204);
      8'h45:   w = {6'h02, 26'h000_0045};
      default: w = 32'hFC00_0000;
    endcase
    return w;
  endfunction

  // Core A memory: ROM below 0x100, RAM above, programmable wait cycles on every access.
  assign a_rdata = (a_addr >= 32'h100) ? a_ram[a_addr[7:2]] : rom_a(a_phase, a_addr[7:2]);
  assign a_ready = a_req && (a_cnt >= a_delay);
  always @(posedge clk) begin
    if (a_req && !a_ready) a_cnt <= a_cnt + 1;
    else a_cnt <= 0;
    if (a_req && a_write && a_ready) a_ram[a_addr[7:2]] <= a_wdata;
  end

  assign b_rdata = rom_b(b_addr[9:2]);
  assign b_ready = b_req;

  mips32_multi #(.RESET_PC(32'h0000_0000), .TRAP_ON_ILLEGAL(1'b1)) u_a (
    .clk(clk), .reset(a_rst_n), .pc(a_pc), .mem_req(a_req), .mem_write(a_write),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ready(a_ready),
    .trap(a_trap)
`ifdef MIPS32_PERF_EN
    , .cycle_cnt(a_cyc), .instret_cnt(a_inst)
`endif
  );

  mips32_multi #(.RESET_PC(32'hF000_0000), .TRAP_ON_ILLEGAL(1'b0)) u_b (
    .clk(clk), .reset(b_rst_n), .pc(b_pc), .mem_req(b_req), .mem_write(b_write),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ready(b_ready),
    .trap(b_trap)
`ifdef MIPS32_PERF_EN
    , .cycle_cnt(b_cyc), .instret_cnt(b_inst)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_acc(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input acc_t e);
    n_tests++;
    if (we !== e.we || addr !== e.addr || (e.we && wd !== e.wd)) begin
      n_fail++;
      $display("FAIL %s: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
               name, we, addr, wd, e.we, e.addr, e.wd);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic fa(input logic [31:0] addr);
    qa.push_back(acc_t'{1'b0, addr, 32'd0});
  endtask
  task automatic la(input logic [31:0] addr);
    qa.push_back(acc_t'{1'b0, addr, 32'd0});
  endtask
  task automatic sa(input logic [31:0] addr, input logic [31:0] wd);
    qa.push_back(acc_t'{1'b1, addr, wd});
  endtask
  task automatic fb(input logic [31:0] addr);
    qb.push_back(acc_t'{1'b0, addr, 32'd0});
  endtask
  task automatic sb(input logic [31:0] addr, input logic [31:0] wd);
    qb.push_back(acc_t'{1'b1, addr, wd});
  endtask

  task automatic drain(input bit sel_b, input int bound);
    int k = 0;
    while (((sel_b ? qb.size() : qa.size()) != 0) && k < bound) begin
      step();
      k++;
    end
    chk(sel_b ? "B trace drained" : "A trace drained",
        sel_b ? qb.size() : qa.size(), 32'd0);
    if (sel_b) qb.delete();
    else qa.delete();
  endtask

  initial begin
    acc_t ea;
    int   k, hold, s1, s2;
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;

    fork
      forever begin
        @(negedge clk);
        #2;
        if (a_req && a_ready) begin
          if (qa.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL A access: got addr=%h we=%b, expected no access", a_addr, a_write);
          end else begin
            ea = qa.pop_front();
            chk_acc("A access", a_write, a_addr, a_wdata, ea);
          end
        end
        if (b_req && b_ready) begin
          if (qb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL B access: got addr=%h we=%b, expected no access", b_addr, b_write);
          end else begin
            ea = qb.pop_front();
            chk_acc("B access", b_write, b_addr, b_wdata, ea);
          end
        end
      end
    join_none

    step();
    step();
    chk("A reset pc", a_pc, 32'h0);
    chk("A reset trap", {31'd0, a_trap}, 32'd0);
    chk("A reset req", {31'd0, a_req}, 32'd0);
    chk("A reset write", {31'd0, a_write}, 32'd0);
    chk("B reset pc", b_pc, 32'hF000_0000);
    chk("B reset req", {31'd0, b_req}, 32'd0);
    chk("B reset trap", {31'd0, b_trap}, 32'd0);

    // Core B: jump keeps pc[31:28], illegal word is a NOP, writes to $0 are dropped.
    fb(32'hF000_0000); fb(32'hF000_0100); fb(32'hF000_0104); fb(32'hF000_0108);
    sb(32'h0000_0200, 32'h0); fb(32'hF000_010C); fb(32'hF000_0110);
    sb(32'h0000_0204, 32'hFFFF_FFFF); fb(32'hF000_0114); fb(32'hF000_0114);
    b_rst_n = 1'b1;
    step();
    chk("B pc after fetch", b_pc, 32'hF000_0004);
    step();
    step();
    chk("B pc after j", b_pc, 32'hF000_0100);
    drain(1'b1, 60);
    b_rst_n = 1'b0;
    step();
`ifdef MIPS32_PERF_EN
    chk("B cycle_cnt after reset", b_cyc, 32'd0);
    chk("B instret_cnt after reset", b_inst, 32'd0);
`endif

    // Core A phase 0: arithmetic, stores/loads with waits, branches.
    fa(32'h00); fa(32'h04); fa(32'h08); fa(32'h0C); sa(32'h100, 32'd12);
    fa(32'h10); la(32'h100); fa(32'h14); sa(32'h104, 32'd12);
    for (int i = 6; i <= 10; i++) fa(i * 4);
    sa(32'h108, 32'hFFFF_FFFE); fa(32'h2C); sa(32'h10C, 32'd1);
    fa(32'h30); sa(32'h110, 32'd5); fa(32'h34); sa(32'h114, 32'd7);
    fa(32'h38); fa(32'h3C); fa(32'h44); la(32'h100);
    fa(32'h48); fa(32'h48); fa(32'h48);
    a_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("A pc after 12 cycles", a_pc, 32'd12);
    a_delay = 3;

    k = 0;
    while (!(a_req && a_write) && k < 40) begin step(); k++; end
    hold = 0;
    while (a_req && a_write && hold < 20) begin
      chk("A store addr held", a_addr, 32'h100);
      chk("A store wdata held", a_wdata, 32'd12);
      hold++;
      step();
    end
    chk("A store req cycles", hold, 32'd4);

    k = 0;
    while (!(a_req && a_ready && !a_write && a_addr == 32'h48) && k < 400) begin step(); k++; end
    s1 = cyc;
    step();
    k = 0;
    while (!(a_req && a_ready && !a_write && a_addr == 32'h48) && k < 40) begin step(); k++; end
    s2 = cyc;
    chk("A beq loop period", s2 - s1, 32'd6);
    drain(1'b0, 40);

    // Phase 1: illegal opcode traps, only reset leaves.
    a_rst_n = 1'b0;
    a_phase = 1;
    a_delay = 0;
    fa(32'h0);
    step();
    a_rst_n = 1'b1;
    step();
    chk("A trap before TRAP", {31'd0, a_trap}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("A trap asserted", {31'd0, a_trap}, 32'd1);
      chk("A trap no req", {31'd0, a_req}, 32'd0);
      chk("A trap pc frozen", a_pc, 32'd4);
      step();
    end

    // Phase 2: reset in the middle of a load wait.
    a_rst_n = 1'b0;
    a_phase = 2;
    a_delay = 10;
    fa(32'h0);
    #1;
    chk("A req during reset", {31'd0, a_req}, 32'd0);
    step();
    a_rst_n = 1'b1;
    #1;
    chk("A trap cleared", {31'd0, a_trap}, 32'd0);
    chk("A pc restart", a_pc, 32'd0);
    chk("A fetch req after reset", {31'd0, a_req}, 32'd1);
    k = 0;
    while (!(a_req && !a_write && a_addr == 32'h118) && k < 40) begin step(); k++; end
    step();
    step();
    chk("A load addr held", a_addr, 32'h118);
    chk("A load req held", {31'd0, a_req}, 32'd1);
    a_rst_n = 1'b0;
    a_phase = 3;
    a_delay = 0;
    #1;
    chk("A req dropped by reset", {31'd0, a_req}, 32'd0);
    fa(32'h0); sa(32'h11C, 32'd12); fa(32'h4); la(32'h100);
    fa(32'h8); sa(32'h120, 32'd12); fa(32'hC);
    step();
    chk("A pc after abort", a_pc, 32'd0);
`ifdef MIPS32_PERF_EN
    chk("A cycle_cnt after reset", a_cyc, 32'd0);
    chk("A instret_cnt after reset", a_inst, 32'd0);
`endif
    a_rst_n = 1'b1;
    #1;
    chk("A fetch addr after abort", a_addr, 32'd0);
    drain(1'b0, 60);
    a_rst_n = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
